// File: rtl/sid_voice_mixer_pkg.sv
// Shared types and constants for the SID voice mixer: sequencer states,
// source indices, datapath widths and the default-width clamp helper.
package sid_voice_mixer_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACC_V1  = 3'd1,
        S_ACC_V2  = 3'd2,
        S_ACC_V3  = 3'd3,
        S_ACC_EXT = 3'd4,
        S_MIX     = 3'd5,
        S_SCALE   = 3'd6
    } state_t;

    localparam int SRC_V1  = 0;
    localparam int SRC_V2  = 1;
    localparam int SRC_V3  = 2;
    localparam int SRC_EXT = 3;

    localparam int VOICE_W = 12;
    localparam int ACC_W   = 14;
    localparam int AUDIO_W = 20;

    // Clamp a 17-bit signed sum into 16 bits (default filter return width).
    function automatic logic [15:0] sat_17to16(input logic [16:0] x);
        if (x[16] != x[15]) begin
            return x[16] ? 16'h8000 : 16'h7FFF;
        end
        return x[15:0];
    endfunction

endpackage

// File: rtl/sid_voice_mixer_saturate.sv
// Parameterised signed clamp from IN_W bits down to OUT_W bits.
// Shared with the filter block, hence kept free of mixer specifics.
module sid_mix_saturate #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  i_din,
    output logic [OUT_W-1:0] o_dout
);

    localparam int HB = IN_W - OUT_W + 1;

    logic [HB-1:0] w_top;
    logic          w_fits;

    // The value fits when every bit above the output sign bit matches it.
    assign w_top  = i_din[IN_W-1:OUT_W-1];
    assign w_fits = (w_top == {HB{1'b0}}) || (w_top == {HB{1'b1}});

    always_comb begin
        o_dout = i_din[OUT_W-1:0];
        if (!w_fits) begin
            if (i_din[IN_W-1]) begin
                o_dout = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                o_dout = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/sid_voice_mixer.sv
// SID voice mixer: routes three voices and ext_in to filter/direct sums with one
// shared adder, mixes the filter return, saturates and applies master volume.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// S_IDLE    | wait for ce_1m, snapshot inputs, clear accumulators
// S_ACC_V1  | accumulate voice1 into its path
// S_ACC_V2  | accumulate voice2 into its path
// S_ACC_V3  | accumulate voice3 (direct path muted by voice3_off)
// S_ACC_EXT | accumulate ext_in, publish filter_in with filter_valid
// S_MIX     | direct sum + filtered_in, saturate to FILT_W
// S_SCALE   | multiply by volume, publish audio_out with audio_valid
module sid_voice_mixer
    import sid_voice_mixer_pkg::*;
#(
    parameter int FILT_W = 16,
    parameter bit EXT_EN = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ce_1m,
    input  logic [11:0]       voice1,
    input  logic [11:0]       voice2,
    input  logic [11:0]       voice3,
    input  logic [11:0]       ext_in,
    input  logic [3:0]        filt_route,
    input  logic              voice3_off,
    input  logic [3:0]        volume,
    input  logic [FILT_W-1:0] filtered_in,
    output logic [13:0]       filter_in,
    output logic              filter_valid,
    output logic [19:0]       audio_out,
    output logic              audio_valid,
    output logic              overrun
);

    localparam int PROD_W = FILT_W + 5;

    state_t                r_state;
    logic [VOICE_W-1:0]    r_v1;
    logic [VOICE_W-1:0]    r_v2;
    logic [VOICE_W-1:0]    r_v3;
    logic [VOICE_W-1:0]    r_ext;
    logic [3:0]            r_route;
    logic                  r_v3_off;
    logic [3:0]            r_vol;
    logic [ACC_W-1:0]      r_filt_acc;
    logic [ACC_W-1:0]      r_dir_acc;
    logic [FILT_W-1:0]     r_sat;

    logic [VOICE_W-1:0]    w_src;
    logic                  w_route;
    logic                  w_mute;
    logic [ACC_W-1:0]      w_operand;
    logic [ACC_W-1:0]      w_acc_a;
    logic [ACC_W-1:0]      w_acc_sum;
    logic signed [FILT_W:0] w_mix_sum;
    logic [FILT_W-1:0]     w_sat;
    logic signed [PROD_W-1:0] w_prod;
    logic [AUDIO_W-1:0]    w_audio;

    always_comb begin
        w_src   = '0;
        w_route = 1'b0;
        w_mute  = 1'b0;
        case (r_state)
            S_ACC_V1: begin
                w_src   = r_v1;
                w_route = r_route[SRC_V1];
            end
            S_ACC_V2: begin
                w_src   = r_v2;
                w_route = r_route[SRC_V2];
            end
            S_ACC_V3: begin
                w_src   = r_v3;
                w_route = r_route[SRC_V3];
                w_mute  = !r_route[SRC_V3] && r_v3_off;
            end
            S_ACC_EXT: begin
                w_src   = r_ext;
                w_route = r_route[SRC_EXT];
                w_mute  = !EXT_EN;
            end
            default: begin
                w_src   = '0;
            end
        endcase
    end

    // One shared adder: the route bit picks which accumulator feeds it.
    assign w_operand = w_mute ? '0 : ACC_W'($signed(w_src));
    assign w_acc_a   = w_route ? r_filt_acc : r_dir_acc;
    assign w_acc_sum = w_acc_a + w_operand;

    assign w_mix_sum = (FILT_W+1)'($signed(r_dir_acc)) + (FILT_W+1)'($signed(filtered_in));

    sid_mix_saturate #(
        .IN_W  (FILT_W + 1),
        .OUT_W (FILT_W)
    ) u_sat (
        .i_din  (w_mix_sum),
        .o_dout (w_sat)
    );

    // Volume is unsigned, so it enters the signed multiply with a zero MSB.
    assign w_prod  = PROD_W'($signed(r_sat)) * PROD_W'($signed({1'b0, r_vol}));
    assign w_audio = AUDIO_W'(w_prod);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_v1         <= '0;
            r_v2         <= '0;
            r_v3         <= '0;
            r_ext        <= '0;
            r_route      <= '0;
            r_v3_off     <= 1'b0;
            r_vol        <= '0;
            r_filt_acc   <= '0;
            r_dir_acc    <= '0;
            r_sat        <= '0;
            filter_in    <= '0;
            filter_valid <= 1'b0;
            audio_out    <= '0;
            audio_valid  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            filter_valid <= 1'b0;
            audio_valid  <= 1'b0;
            if (ce_1m && (r_state != S_IDLE)) begin
                overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (ce_1m) begin
                        r_v1       <= voice1;
                        r_v2       <= voice2;
                        r_v3       <= voice3;
                        r_ext      <= ext_in;
                        r_route    <= filt_route;
                        r_v3_off   <= voice3_off;
                        r_vol      <= volume;
                        r_filt_acc <= '0;
                        r_dir_acc  <= '0;
                        r_state    <= S_ACC_V1;
                    end
                end
                S_ACC_V1, S_ACC_V2, S_ACC_V3: begin
                    if (w_route) begin
                        r_filt_acc <= w_acc_sum;
                    end else begin
                        r_dir_acc  <= w_acc_sum;
                    end
                    r_state <= state_t'(r_state + 3'd1);
                end
                S_ACC_EXT: begin
                    if (w_route) begin
                        r_filt_acc <= w_acc_sum;
                        filter_in  <= w_acc_sum;
                    end else begin
                        r_dir_acc  <= w_acc_sum;
                        filter_in  <= r_filt_acc;
                    end
                    filter_valid <= 1'b1;
                    r_state      <= S_MIX;
                end
                S_MIX: begin
                    r_sat   <= w_sat;
                    r_state <= S_SCALE;
                end
                S_SCALE: begin
                    audio_out   <= w_audio;
                    audio_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
